// File: rtl/systolic_array_ws.sv
// systolic_array_ws: weight-stationary ROWS x COLS signed MAC array.
// Weights are loaded one row per beat and held in place; input vectors are
// skewed into the rows, partial sums flow down the columns and are deskewed
// so that every result leaves as one aligned vector on out_valid.
module systolic_array_ws #(
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 2*DATA_W + $clog2(ROWS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   w_valid,
    output logic                   w_ready,
    input  logic [COLS*DATA_W-1:0] w_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [ROWS*DATA_W-1:0] in_data,
    output logic                   out_valid,
    output logic [COLS*ACC_W-1:0]  out_data,
    output logic                   busy
);

    localparam int LAT   = ROWS + COLS;
    localparam int CNT_W = $clog2(LAT + 1);
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_t;

    state_t            state, state_next;
    logic              loaded;
    logic [ROW_W-1:0]  row_cnt;
    logic [ROW_W-1:0]  wr_row;
    logic [CNT_W-1:0]  inflight;
    logic              w_fire;
    logic              in_fire;
    logic              drain_done;
    logic [LAT-2:0]    vpipe;

    logic signed [DATA_W-1:0] weight  [ROWS][COLS];
    logic signed [DATA_W-1:0] x_in    [ROWS][COLS];
    logic signed [ACC_W-1:0]  psum    [ROWS][COLS];
    logic signed [ACC_W-1:0]  col_out [COLS];

    assign w_fire  = w_valid & w_ready;
    assign in_fire = in_valid & in_ready;
    assign wr_row  = (state == IDLE) ? '0 : row_cnt;
    assign busy    = (state != IDLE) || (inflight != '0);

    // The pipeline is empty once this cycle's result (if any) has left and nothing new enters.
    assign drain_done = (inflight == '0) || ((inflight == CNT_W'(1)) && out_valid);

    // Next-state and handshake decode; a pending weight beat always wins over input.
    always_comb begin
        state_next = state;
        w_ready    = 1'b0;
        in_ready   = 1'b0;
        case (state)
            IDLE: begin
                w_ready  = 1'b1;
                in_ready = loaded & ~w_valid;
                if (w_valid) begin
                    if (ROWS > 1)
                        state_next = LOAD;
                end else if (in_valid && loaded) begin
                    state_next = RUN;
                end
            end
            LOAD: begin
                w_ready = 1'b1;
                if (w_valid && (row_cnt == ROW_W'(ROWS-1)))
                    state_next = IDLE;
            end
            RUN: begin
                in_ready = ~w_valid;
                if (w_valid)
                    state_next = DRAIN;
                else if (!in_valid && drain_done)
                    state_next = IDLE;
            end
            DRAIN: begin
                if (drain_done)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State register, load progress and in-flight bookkeeping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            loaded   <= 1'b0;
            row_cnt  <= '0;
            inflight <= '0;
        end else begin
            state <= state_next;
            case ({in_fire, out_valid})
                2'b10:   inflight <= inflight + CNT_W'(1);
                2'b01:   inflight <= inflight - CNT_W'(1);
                default: inflight <= inflight;
            endcase
            if (w_fire) begin
                if (state == IDLE) begin
                    if (ROWS == 1) begin
                        loaded <= 1'b1;
                    end else begin
                        loaded  <= 1'b0;
                        row_cnt <= ROW_W'(1);
                    end
                end else if (row_cnt == ROW_W'(ROWS-1)) begin
                    loaded  <= 1'b1;
                    row_cnt <= '0;
                end else begin
                    row_cnt <= row_cnt + ROW_W'(1);
                end
            end
        end
    end

    // Stationary weight storage, written one row per accepted beat.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    weight[r][c] <= '0;
        end else if (w_fire) begin
            for (int c = 0; c < COLS; c++)
                weight[wr_row][c] <= w_data[c*DATA_W +: DATA_W];
        end
    end

    genvar r, c;

    // Input skew: row r reaches PE(r,0) r cycles after acceptance; bubbles inject zero.
    for (r = 0; r < ROWS; r++) begin : g_skew
        logic signed [DATA_W-1:0] x_new;
        assign x_new = in_fire ? in_data[r*DATA_W +: DATA_W] : '0;
        if (r == 0) begin : g_direct
            assign x_in[0][0] = x_new;
        end else begin : g_delay
            logic signed [DATA_W-1:0] dly [r];
            // Shift chain delaying this row's element.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int k = 0; k < r; k++)
                        dly[k] <= '0;
                end else begin
                    dly[0] <= x_new;
                    for (int k = 1; k < r; k++)
                        dly[k] <= dly[k-1];
                end
            end
            assign x_in[r][0] = dly[r-1];
        end
    end

    // PE grid: data moves right one PE per cycle, partial sums move down one PE per cycle.
    for (r = 0; r < ROWS; r++) begin : g_row
        for (c = 0; c < COLS; c++) begin : g_pe
            logic signed [2*DATA_W-1:0] prod;
            logic signed [ACC_W-1:0]    psum_above;
            logic signed [ACC_W-1:0]    psum_q;
            assign prod = x_in[r][c] * weight[r][c];
            if (r == 0) begin : g_top
                assign psum_above = '0;
            end else begin : g_inner
                assign psum_above = psum[r-1][c];
            end
            // Multiply-accumulate; the sum wraps modulo 2^ACC_W.
            always_ff @(posedge clk or posedge reset) begin
                if (reset)
                    psum_q <= '0;
                else
                    psum_q <= psum_above + ACC_W'(prod);
            end
            assign psum[r][c] = psum_q;
            if (c < COLS-1) begin : g_pass
                logic signed [DATA_W-1:0] x_q;
                // Forward the input element to the right-hand neighbour.
                always_ff @(posedge clk or posedge reset) begin
                    if (reset)
                        x_q <= '0;
                    else
                        x_q <= x_in[r][c];
                end
                assign x_in[r][c+1] = x_q;
            end
        end
    end

    // Output deskew: column c is held back COLS-1-c cycles so all columns line up.
    for (c = 0; c < COLS; c++) begin : g_deskew
        localparam int D = COLS - 1 - c;
        if (D == 0) begin : g_direct
            assign col_out[c] = psum[ROWS-1][c];
        end else begin : g_delay
            logic signed [ACC_W-1:0] dly [D];
            // Shift chain delaying this column's finished sum.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int k = 0; k < D; k++)
                        dly[k] <= '0;
                end else begin
                    dly[0] <= psum[ROWS-1][c];
                    for (int k = 1; k < D; k++)
                        dly[k] <= dly[k-1];
                end
            end
            assign col_out[c] = dly[D-1];
        end
    end

    // Valid tag travelling alongside the data so bubbles never produce output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vpipe <= '0;
        end else begin
            vpipe[0] <= in_fire;
            for (int i = 1; i < LAT-1; i++)
                vpipe[i] <= vpipe[i-1];
        end
    end

    // Result register: updates only with a valid result and otherwise holds.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= vpipe[LAT-2];
            if (vpipe[LAT-2]) begin
                for (int k = 0; k < COLS; k++)
                    out_data[k*ACC_W +: ACC_W] <= col_out[k];
            end
        end
    end

endmodule
